// File: rtl/writeback_arbiter.sv
// Round-robin writeback arbiter: picks one completed execution-unit result per cycle
// and registers it toward the register file write port. WB_ARB_PERF_COUNTERS_EN adds wb_conflict_count.
module writeback_arbiter #(
  parameter int NUM_UNITS = 4,
  parameter int XLEN      = 32,
  parameter int ID_W      = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_UNITS-1:0]      unit_done,
  input  logic [NUM_UNITS*5-1:0]    unit_rd_addr,
  input  logic [NUM_UNITS*XLEN-1:0] unit_rd_data,
  input  logic [NUM_UNITS*ID_W-1:0] unit_id,
  output logic [NUM_UNITS-1:0]      unit_ack,
  output logic                      wb_valid_write,
  output logic [4:0]                wb_rd_addr,
  output logic [XLEN-1:0]           wb_rd_data,
  output logic [ID_W-1:0]           wb_id
`ifdef WB_ARB_PERF_COUNTERS_EN
  ,
  output logic [31:0]               wb_conflict_count
`endif
);

  localparam int PTR_W = $clog2(NUM_UNITS);

  // Handshake: unit i holds unit_done[i] and its fields stable until it sees
  // unit_ack[i] high in the same cycle; the transfer happens on that clock edge.

  logic [PTR_W-1:0]     r_rr_ptr;
  logic                 r_wb_valid;
  logic [4:0]           r_wb_rd_addr;
  logic [XLEN-1:0]      r_wb_rd_data;
  logic [ID_W-1:0]      r_wb_id;

  int                   w_scan_idx;
  logic                 w_grant_any;
  logic [PTR_W-1:0]     w_grant_idx;
  logic                 w_accept;
  logic [NUM_UNITS-1:0] w_grant_oh;
  logic [PTR_W-1:0]     w_next_ptr;
  logic [4:0]           w_sel_addr;
  logic [XLEN-1:0]      w_sel_data;
  logic [ID_W-1:0]      w_sel_id;
  logic                 w_sel_nonzero;

  // Scan units starting at r_rr_ptr, wrapping, and take the first requester.
  always_comb begin
    w_scan_idx  = 0;
    w_grant_any = 1'b0;
    w_grant_idx = '0;
    for (int k = 0; k < NUM_UNITS; k++) begin
      w_scan_idx = int'(r_rr_ptr) + k;
      if (w_scan_idx >= NUM_UNITS) begin
        w_scan_idx = w_scan_idx - NUM_UNITS;
      end
      if (!w_grant_any && unit_done[w_scan_idx]) begin
        w_grant_any = 1'b1;
        w_grant_idx = PTR_W'(w_scan_idx);
      end
    end
  end

  always_comb begin
    w_accept   = w_grant_any && !rst;
    w_grant_oh = '0;
    if (w_accept) begin
      w_grant_oh = NUM_UNITS'(1) << w_grant_idx;
    end
  end

  always_comb begin
    if (w_grant_idx == PTR_W'(NUM_UNITS - 1)) begin
      w_next_ptr = '0;
    end else begin
      w_next_ptr = w_grant_idx + PTR_W'(1);
    end
  end

  always_comb begin
    w_sel_addr    = unit_rd_addr[int'(w_grant_idx)*5 +: 5];
    w_sel_data    = unit_rd_data[int'(w_grant_idx)*XLEN +: XLEN];
    w_sel_id      = unit_id[int'(w_grant_idx)*ID_W +: ID_W];
    w_sel_nonzero = (w_sel_addr != 5'd0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rr_ptr <= '0;
    end else if (w_accept) begin
      r_rr_ptr <= w_next_ptr;
    end
  end

  // x0 completions are acked and advance the pointer but never reach the register file.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wb_valid   <= 1'b0;
      r_wb_rd_addr <= '0;
      r_wb_rd_data <= '0;
      r_wb_id      <= '0;
    end else begin
      r_wb_valid <= w_accept && w_sel_nonzero;
      if (w_accept && w_sel_nonzero) begin
        r_wb_rd_addr <= w_sel_addr;
        r_wb_rd_data <= w_sel_data;
        r_wb_id      <= w_sel_id;
      end
    end
  end

  assign unit_ack       = w_grant_oh;
  assign wb_valid_write = r_wb_valid;
  assign wb_rd_addr     = r_wb_rd_addr;
  assign wb_rd_data     = r_wb_rd_data;
  assign wb_id          = r_wb_id;

`ifdef WB_ARB_PERF_COUNTERS_EN
  logic [31:0] r_conflict_cnt;
  logic        w_multi_req;

  // Clearing the lowest set bit leaves something only when two or more bits are set.
  assign w_multi_req = |(unit_done & (unit_done - NUM_UNITS'(1)));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_conflict_cnt <= '0;
    end else if (w_multi_req && (r_conflict_cnt != 32'hFFFF_FFFF)) begin
      r_conflict_cnt <= r_conflict_cnt + 32'd1;
    end
  end

  assign wb_conflict_count = r_conflict_cnt;
`endif

endmodule

// File: tb/tb_writeback_arbiter.sv
// Testbench for writeback_arbiter: directed scenarios plus randomized traffic,
// checked by a priority-list reference model feeding an expected-write queue.
module tb_writeback_arbiter;
  localparam int N    = 4;
  localparam int XLEN = 32;
  localparam int ID_W = 2;
  localparam int W    = 5 + XLEN + ID_W;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [N-1:0]      unit_done;
  logic [N*5-1:0]    unit_rd_addr;
  logic [N*XLEN-1:0] unit_rd_data;
  logic [N*ID_W-1:0] unit_id;
  logic [N-1:0]      unit_ack;
  logic              wb_valid_write;
  logic [4:0]        wb_rd_addr;
  logic [XLEN-1:0]   wb_rd_data;
  logic [ID_W-1:0]   wb_id;
`ifdef WB_ARB_PERF_COUNTERS_EN
  logic [31:0]       wb_conflict_count;
`endif

  writeback_arbiter #(.NUM_UNITS(N), .XLEN(XLEN), .ID_W(ID_W)) dut (
    .clk            (clk),
    .rst            (rst),
    .unit_done      (unit_done),
    .unit_rd_addr   (unit_rd_addr),
    .unit_rd_data   (unit_rd_data),
    .unit_id        (unit_id),
    .unit_ack       (unit_ack),
    .wb_valid_write (wb_valid_write),
    .wb_rd_addr     (wb_rd_addr),
    .wb_rd_data     (wb_rd_data),
    .wb_id          (wb_id)
`ifdef WB_ARB_PERF_COUNTERS_EN
    ,
    .wb_conflict_count (wb_conflict_count)
`endif
  );

  // clock / reset
  always #5 clk = ~clk;

  // unit-side driver state
  logic            d_done [N];
  logic [4:0]      d_addr [N];
  logic [XLEN-1:0] d_data [N];
  logic [ID_W-1:0] d_id   [N];
  logic            unit_en [N];
  int              mode;
  logic [N-1:0]    seen_ack;

  always_comb begin
    unit_done    = '0;
    unit_rd_addr = '0;
    unit_rd_data = '0;
    unit_id      = '0;
    for (int u = 0; u < N; u++) begin
      unit_done[u]               = d_done[u];
      unit_rd_addr[u*5 +: 5]     = d_addr[u];
      unit_rd_data[u*XLEN +: XLEN] = d_data[u];
      unit_id[u*ID_W +: ID_W]    = d_id[u];
    end
  end

  // scoreboard state
  int              checks = 0;
  int              errors = 0;
  logic [W-1:0]    exp_q[$];
  int              prio[N];
  logic [31:0]     model_cnt = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic set_req(input int u, input logic [4:0] a, input logic [XLEN-1:0] d,
                         input logic [ID_W-1:0] id);
    d_done[u] = 1'b1;
    d_addr[u] = a;
    d_data[u] = d;
    d_id[u]   = id;
  endtask

  task automatic new_req(input int u);
    logic [4:0] a;
    a = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
    set_req(u, a, $urandom, ID_W'($urandom_range(0, (1 << ID_W) - 1)));
  endtask

  // Release acked requests, then optionally present new ones (mode 1: always, 2: random).
  task automatic drive_step();
    for (int u = 0; u < N; u++) begin
      if (d_done[u] && seen_ack[u]) d_done[u] = 1'b0;
      if (!d_done[u] && unit_en[u]) begin
        if (mode == 1 || (mode == 2 && $urandom_range(0, 99) < 60)) new_req(u);
      end
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      drive_step();
    end
  endtask

  task automatic set_en(input logic [N-1:0] m);
    for (int u = 0; u < N; u++) unit_en[u] = m[u];
  endtask

  // Reference model: an ordered priority list; the granted unit moves to the back.
  always @(negedge clk) begin
    int g;
    int nreq;
    logic [N-1:0] exp_ack;
    seen_ack = unit_ack;
    exp_ack  = '0;
    if (rst) begin
      for (int i = 0; i < N; i++) prio[i] = i;
      model_cnt = '0;
    end else begin
      g = -1;
      foreach (prio[i]) if (g < 0 && d_done[prio[i]]) g = prio[i];
      if (g >= 0) begin
        exp_ack[g] = 1'b1;
        for (int i = 0; i < N; i++) prio[i] = (g + 1 + i) % N;
        if (d_addr[g] != 5'd0) exp_q.push_back({d_addr[g], d_data[g], d_id[g]});
      end
      nreq = 0;
      for (int u = 0; u < N; u++) if (d_done[u]) nreq++;
      if (nreq >= 2 && model_cnt != 32'hFFFF_FFFF) model_cnt = model_cnt + 32'd1;
    end
    check("unit_ack", 64'(unit_ack), 64'(exp_ack));
  end

  // Monitor: every presented write must match the oldest expected one.
  always @(posedge clk) begin
    logic [W-1:0] exp;
    #2;
    checks++;
    if (wb_valid_write !== 1'b0) begin
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL wb_spurious: got valid=%b addr=%0d expected no write", wb_valid_write, wb_rd_addr);
      end else begin
        exp = exp_q.pop_front();
        if ({wb_rd_addr, wb_rd_data, wb_id} !== exp) begin
          errors++;
          $display("FAIL wb_fields: got %0h expected %0h", {wb_rd_addr, wb_rd_data, wb_id}, exp);
        end
      end
    end else if (exp_q.size() != 0) begin
      exp = exp_q.pop_front();
      errors++;
      $display("FAIL wb_missing: got valid=0 expected write %0h", exp);
    end
`ifdef WB_ARB_PERF_COUNTERS_EN
    check("conflict_count", 64'(wb_conflict_count), 64'(model_cnt));
`endif
  end

  initial begin
    mode = 0;
    seen_ack = '0;
    for (int u = 0; u < N; u++) begin
      d_done[u] = 1'b0;
      d_addr[u] = '0;
      d_data[u] = '0;
      d_id[u]   = '0;
      unit_en[u] = 1'b0;
    end
    repeat (3) @(posedge clk);
    #1;
    check("rst_valid", 64'(wb_valid_write), 64'd0);
    check("rst_addr", 64'(wb_rd_addr), 64'd0);
    check("rst_data", 64'(wb_rd_data), 64'd0);
    check("rst_id", 64'(wb_id), 64'd0);
    rst = 1'b0;

    // single request from unit 2
    cycles(2);
    set_req(2, 5'd5, 32'hDEADBEEF, 2'd1);
    #3;
    check("single_ack", 64'(unit_ack), 64'b0100);
    cycles(1);
    #1;
    check("single_valid", 64'(wb_valid_write), 64'd1);
    check("single_addr", 64'(wb_rd_addr), 64'd5);
    check("single_data", 64'(wb_rd_data), 64'hDEADBEEF);
    check("single_id", 64'(wb_id), 64'd1);
    cycles(1);
    #1;
    check("single_idle", 64'(wb_valid_write), 64'd0);

    // wrap and skip: pointer at 3, units 0 and 3 -> 3 then 0; then 0 and 1 -> 1
    set_req(0, 5'd7, 32'h1111_0000, 2'd2);
    set_req(3, 5'd9, 32'h3333_0000, 2'd3);
    cycles(3);
    set_req(0, 5'd10, 32'h1111_0001, 2'd0);
    set_req(1, 5'd11, 32'h2222_0001, 2'd1);
    cycles(4);

    // x0 suppression on unit 1, then units 1 and 2 -> 2 first
    set_req(1, 5'd0, 32'hBAD0_0000, 2'd1);
    cycles(3);
    set_req(1, 5'd12, 32'h2222_0002, 2'd2);
    set_req(2, 5'd13, 32'h4444_0002, 2'd3);
    cycles(4);

    // all four requesting continuously from reset
    rst = 1'b1;
    cycles(2);
    rst = 1'b0;
    set_en(4'b1111);
    mode = 1;
    cycles(12);
    set_en(4'b0000);
    cycles(6);

    // reset in the middle of traffic from units 0 and 1
    set_en(4'b0011);
    cycles(5);
    rst = 1'b1;
    cycles(2);
    rst = 1'b0;
    cycles(4);
    set_en(4'b0000);
    cycles(6);

`ifdef WB_ARB_PERF_COUNTERS_EN
    // 10 cycles with three requesters, then 5 cycles with one
    rst = 1'b1;
    cycles(2);
    rst = 1'b0;
    set_en(4'b0111);
    cycles(10);
    @(posedge clk);
    #1;
    for (int u = 0; u < 3; u++) d_done[u] = 1'b0;
    set_en(4'b1000);
    drive_step();
    cycles(4);
    @(posedge clk);
    #2;
    check("conflict_directed", 64'(wb_conflict_count), 64'd10);
    #1;
    set_en(4'b0000);
    mode = 0;
    cycles(6);
`endif

    // randomized traffic with occasional resets
    mode = 2;
    set_en(4'b1111);
    for (int i = 0; i < 2000; i++) begin
      rst = ($urandom_range(0, 199) == 0);
      cycles(1);
    end
    rst = 1'b0;
    set_en(4'b0000);
    mode = 0;
    cycles(12);

    check("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
